// File: rtl/ook_frame_tx_if.sv
// Byte-stream handshake bundle for the OOK frame transmitter.
//   tdata  : payload byte
//   tvalid : byte valid
//   tlast  : last byte of the payload
//   tready : receiver accepts a byte
// A beat transfers on a rising clock edge where tvalid & tready are both high;
// tdata/tlast carry no meaning while tvalid is low, and a source may raise or
// drop tvalid freely between beats.
interface ook_frame_tx_if;
  logic [7:0] tdata;
  logic       tvalid;
  logic       tlast;
  logic       tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/ook_frame_tx.sv
// Frame builder and OOK chip generator. Buffers one payload from the byte
// stream, then sends preamble (0x55 x PREAMBLE_BYTES), SFD (0xD5), length,
// payload and CRC-8 (poly 0x07, init 0), MSB first, each bit held BIT_CLKS
// clocks and replicated on all 32 GT lanes, followed by IFG_BITS zero bits.
// Ports:
//   clk, gt0_tx_system_reset : clock, synchronous active-high reset
//   s                        : byte-stream slave (tdata/tvalid/tlast/tready)
//   gt0_txdata               : {32{chip}}, chip 1 = light on
//   tx_busy                  : high outside IDLE/LOAD
//   frame_done               : high on the last gap cycle
//   ovf_err                  : one-cycle pulse when a payload is dropped
//   dbg_state                : current FSM state
module ook_frame_tx #(
  parameter int MAX_PAYLOAD    = 64,
  parameter int PREAMBLE_BYTES = 4,
  parameter int BIT_CLKS       = 16,
  parameter int IFG_BITS       = 16
) (
  input  logic          clk,
  input  logic          gt0_tx_system_reset,
  ook_frame_tx_if.slave s,
  output logic [31:0]   gt0_txdata,
  output logic          tx_busy,
  output logic          frame_done,
  output logic          ovf_err,
  output logic [3:0]    dbg_state
);
  localparam int DIV_W   = (BIT_CLKS > 1) ? $clog2(BIT_CLKS) : 1;
  localparam int GAP_CYC = IFG_BITS * BIT_CLKS;
  localparam int GAP_W   = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
  localparam int AW      = (MAX_PAYLOAD > 1) ? $clog2(MAX_PAYLOAD) : 1;

  typedef enum logic [3:0] {
    IDLE, LOAD, DROP, PREAMBLE, SFD, LEN, PAYLOAD, CRC, GAP
  } state_t;

  state_t           state, state_n;
  logic [7:0]       count, count_n;
  logic [7:0]       idx, idx_n;
  logic [7:0]       sh, sh_n;
  logic [2:0]       bit_cnt, bit_n;
  logic [DIV_W-1:0] div, div_n;
  logic [GAP_W-1:0] gap_cnt, gap_n;
  logic [7:0]       crc, crc_n;
  logic             chip, tready_q, busy_q, ovf_q, ovf_n;
  logic             acc, bit_end, byte_end, sending, wr_en;
  logic [AW-1:0]    rd_idx;
  logic [7:0]       rd_byte;
  logic [7:0]       pbuf [MAX_PAYLOAD];

  function automatic logic [7:0] crc8(input logic [7:0] c, input logic [7:0] d);
    logic [7:0] r;
    r = c ^ d;
    for (int i = 0; i < 8; i++) begin
      r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
    end
    return r;
  endfunction

  assign acc      = s.tvalid & tready_q;
  assign bit_end  = (div == DIV_W'(BIT_CLKS - 1));
  assign byte_end = bit_end & (bit_cnt == 3'd7);
  assign sending  = (state inside {PREAMBLE, SFD, LEN, PAYLOAD, CRC});

  // Buffer read is a plain mux from the register array, so the next byte is
  // ready in the same cycle the current one finishes: no bubble between bytes.
  assign rd_idx  = (state == LEN) ? '0 : AW'(idx + 8'd1);
  assign rd_byte = pbuf[rd_idx];

  always_comb begin
    state_n = state;
    count_n = count;
    idx_n   = idx;
    sh_n    = sh;
    bit_n   = bit_cnt;
    div_n   = div;
    gap_n   = gap_cnt;
    crc_n   = crc;
    ovf_n   = 1'b0;
    wr_en   = 1'b0;

    if (sending) begin
      if (bit_end) begin
        div_n = '0;
        bit_n = bit_cnt + 3'd1;
        sh_n  = sh << 1;
      end else begin
        div_n = div + DIV_W'(1);
      end
    end

    case (state)
      IDLE, LOAD: begin
        if (acc) begin
          if (state == LOAD && count == 8'(MAX_PAYLOAD)) begin
            // Overflowing byte is discarded; a tlast here ends the drop at once.
            ovf_n   = 1'b1;
            state_n = s.tlast ? IDLE : DROP;
            count_n = s.tlast ? 8'd0 : count;
          end else begin
            wr_en   = 1'b1;
            count_n = count + 8'd1;
            state_n = LOAD;
            if (s.tlast) begin
              state_n = PREAMBLE;
              sh_n    = 8'h55;
              idx_n   = 8'd0;
              bit_n   = 3'd0;
              div_n   = '0;
            end
          end
        end
      end
      DROP: begin
        if (acc && s.tlast) begin
          state_n = IDLE;
          count_n = 8'd0;
        end
      end
      PREAMBLE: begin
        if (byte_end) begin
          if (idx == 8'(PREAMBLE_BYTES - 1)) begin
            state_n = SFD;
            sh_n    = 8'hD5;
          end else begin
            idx_n = idx + 8'd1;
            sh_n  = 8'h55;
          end
        end
      end
      SFD: begin
        if (byte_end) begin
          state_n = LEN;
          sh_n    = count;
          crc_n   = crc8(8'h00, count);
        end
      end
      LEN: begin
        if (byte_end) begin
          state_n = PAYLOAD;
          idx_n   = 8'd0;
          sh_n    = rd_byte;
          crc_n   = crc8(crc, rd_byte);
        end
      end
      PAYLOAD: begin
        if (byte_end) begin
          if (idx == count - 8'd1) begin
            state_n = CRC;
            sh_n    = crc;
          end else begin
            idx_n = idx + 8'd1;
            sh_n  = rd_byte;
            crc_n = crc8(crc, rd_byte);
          end
        end
      end
      CRC: begin
        if (byte_end) begin
          state_n = GAP;
          gap_n   = '0;
        end
      end
      GAP: begin
        if (gap_cnt == GAP_W'(GAP_CYC - 1)) begin
          state_n = IDLE;
          count_n = 8'd0;
        end else begin
          gap_n = gap_cnt + GAP_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Output flops are loaded from next-state values so chips, tready and
  // tx_busy change on the same edge as the state they belong to.
  always_ff @(posedge clk) begin
    if (gt0_tx_system_reset) begin
      state    <= IDLE;
      count    <= 8'd0;
      idx      <= 8'd0;
      sh       <= 8'd0;
      bit_cnt  <= 3'd0;
      div      <= '0;
      gap_cnt  <= '0;
      crc      <= 8'd0;
      chip     <= 1'b0;
      tready_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state    <= state_n;
      count    <= count_n;
      idx      <= idx_n;
      sh       <= sh_n;
      bit_cnt  <= bit_n;
      div      <= div_n;
      gap_cnt  <= gap_n;
      crc      <= crc_n;
      chip     <= (state_n inside {PREAMBLE, SFD, LEN, PAYLOAD, CRC}) & sh_n[7];
      tready_q <= (state_n inside {IDLE, LOAD, DROP});
      busy_q   <= !(state_n inside {IDLE, LOAD});
      ovf_q    <= ovf_n;
    end
  end

  // Payload storage carries no reset: its content is don't-care until rewritten.
  always_ff @(posedge clk) begin
    if (wr_en) pbuf[AW'(count)] <= s.tdata;
  end

  assign s.tready   = tready_q;
  assign gt0_txdata = {32{chip}};
  assign tx_busy    = busy_q;
  assign ovf_err    = ovf_q;
  assign frame_done = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYC - 1));
  assign dbg_state  = state;
endmodule

// File: tb/tb_ook_frame_tx.sv
module tb_ook_frame_tx;
  localparam int IFG  = 16;
  localparam int MAXP = 64;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ook_frame_tx_if if_a ();
  ook_frame_tx_if if_b ();

  logic [31:0] txd_a, txd_b;
  logic        busy_a, busy_b, done_a, done_b, ovf_a, ovf_b;
  logic [3:0]  st_a, st_b;

  // dut_a: fast chips, short preamble; dut_b: default parameters
  ook_frame_tx #(.MAX_PAYLOAD(MAXP), .PREAMBLE_BYTES(1), .BIT_CLKS(1), .IFG_BITS(IFG)) dut_a (
    .clk(clk), .gt0_tx_system_reset(rst), .s(if_a), .gt0_txdata(txd_a),
    .tx_busy(busy_a), .frame_done(done_a), .ovf_err(ovf_a), .dbg_state(st_a));
  ook_frame_tx dut_b (
    .clk(clk), .gt0_tx_system_reset(rst), .s(if_b), .gt0_txdata(txd_b),
    .tx_busy(busy_b), .frame_done(done_b), .ovf_err(ovf_b), .dbg_state(st_b));

  logic       sel;
  logic [7:0] d_data;
  logic       d_valid, d_last;

  assign if_a.tdata  = d_data;
  assign if_a.tlast  = d_last;
  assign if_a.tvalid = d_valid & ~sel;
  assign if_b.tdata  = d_data;
  assign if_b.tlast  = d_last;
  assign if_b.tvalid = d_valid & sel;

  wire        m_tready = sel ? if_b.tready : if_a.tready;
  wire [31:0] m_txd    = sel ? txd_b : txd_a;
  wire        m_busy   = sel ? busy_b : busy_a;
  wire        m_done   = sel ? done_b : done_a;
  wire        m_ovf    = sel ? ovf_b : ovf_a;

  function automatic int bclk();
    return sel ? 16 : 1;
  endfunction
  function automatic int pre();
    return sel ? 4 : 1;
  endfunction

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [7:0] pl_q[$];
  logic [0:0] exp_q[$];
  logic [7:0] exp_b[$];
  logic [7:0] rx_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int   ovf_cnt = 0;
  int   zero_viol = 0;
  logic watch_zero = 1'b0;
  always @(negedge clk) begin
    if (m_ovf) ovf_cnt++;
    if (watch_zero && m_txd != 32'd0) zero_viol++;
  end

  // CRC as remainder of (message * x^8) divided by x^8+x^2+x+1
  function automatic logic [7:0] crc_model();
    logic       m[$];
    logic [8:0] poly;
    logic [7:0] len;
    logic [7:0] r;
    poly = 9'h107;
    len  = 8'(pl_q.size());
    for (int b = 7; b >= 0; b--) m.push_back(len[b]);
    foreach (pl_q[k]) begin
      logic [7:0] v;
      v = pl_q[k];
      for (int b = 7; b >= 0; b--) m.push_back(v[b]);
    end
    repeat (8) m.push_back(1'b0);
    for (int i = 0; i + 8 < m.size(); i++) begin
      if (m[i]) begin
        for (int j = 0; j < 9; j++) m[i+j] = m[i+j] ^ poly[8-j];
      end
    end
    for (int j = 0; j < 8; j++) r[7-j] = m[m.size()-8+j];
    return r;
  endfunction

  task automatic build_exp();
    exp_q.delete();
    exp_b.delete();
    for (int p = 0; p < pre(); p++) exp_b.push_back(8'h55);
    exp_b.push_back(8'hD5);
    exp_b.push_back(8'(pl_q.size()));
    foreach (pl_q[k]) exp_b.push_back(pl_q[k]);
    exp_b.push_back(crc_model());
    foreach (exp_b[k]) begin
      logic [7:0] v;
      v = exp_b[k];
      for (int b = 7; b >= 0; b--) repeat (bclk()) exp_q.push_back(v[b]);
    end
    repeat (IFG * bclk()) exp_q.push_back(1'b0);
  endtask

  // ---------------- driver ----------------
  // Called at a negedge; returns at the negedge after the last beat's edge.
  task automatic send_frame(input int bubbles, output int first_wait);
    int w;
    first_wait = 0;
    for (int k = 0; k < pl_q.size(); k++) begin
      if (bubbles != 0) begin
        d_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      d_valid = 1'b1;
      d_data  = pl_q[k];
      d_last  = (k == pl_q.size() - 1);
      w = 0;
      while (!m_tready && w < 12000) begin
        @(negedge clk);
        w++;
      end
      if (w >= 12000) check("beat_timeout", 32'(w), 32'd0);
      if (k == 0) first_wait = w;
      @(posedge clk);
      @(negedge clk);
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
  endtask

  // Walks every cycle from the first preamble chip to the end of the gap.
  task automatic monitor_frame(input bit poke);
    int n, fchips, nb;
    logic [7:0] cur;
    build_exp();
    n      = exp_q.size();
    fchips = exp_b.size() * 8 * bclk();
    rx_q.delete();
    nb  = 0;
    cur = 8'd0;
    if (poke) begin
      d_valid = 1'b1;
      d_data  = 8'($urandom_range(0, 255));
      d_last  = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < n; i++) begin
      check("chip", m_txd, {32{exp_q[i]}});
      check("frame_done", 32'(m_done), 32'(i == n - 1));
      check("rdy_busy_tx", 32'({m_tready, m_busy}), 32'b01);
      if (i < fchips && (i % bclk()) == 0) begin
        cur = {cur[6:0], m_txd[0]};
        nb++;
        if (nb == 8) begin
          rx_q.push_back(cur);
          nb = 0;
        end
      end
      @(negedge clk);
    end
    d_valid = 1'b0;
    d_last  = 1'b0;
    check("rdy_busy_after", 32'({m_tready, m_busy}), 32'b10);
  endtask

  task automatic random_payload(input int len);
    pl_q.delete();
    repeat (len) pl_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int fw, o0;
    sel = 1'b0; d_valid = 1'b0; d_data = 8'd0; d_last = 1'b0; rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_a", 32'({if_a.tready, busy_a, done_a, ovf_a, |txd_a}), 32'd0);
    check("rst_b", 32'({if_b.tready, busy_b, done_b, ovf_b, |txd_b}), 32'd0);
    check("rst_state", 32'({st_a, st_b}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("rdy_after_rst", 32'({if_a.tready, if_b.tready}), 32'b11);

    // single byte, 1 clock per chip
    pl_q = '{8'h00};
    send_frame(0, fw);
    monitor_frame(0);
    check("single_nbytes", 32'(rx_q.size()), 32'd5);
    check("single_len", 32'(rx_q[2]), 32'h01);
    check("single_crc", 32'(rx_q[4]), 32'h15);

    // random frames, random bubbles, beats offered during transmission
    for (int f = 0; f < 6; f++) begin
      random_payload($urandom_range(1, 10));
      send_frame($urandom_range(0, 1), fw);
      monitor_frame(1);
    end

    // back-to-back: second frame offered right after frame_done
    random_payload(3);
    send_frame(0, fw);
    monitor_frame(0);
    random_payload(2);
    send_frame(0, fw);
    check("b2b_first_wait", 32'(fw), 32'd0);
    monitor_frame(0);

    // default parameters: max payload
    sel = 1'b1;
    @(negedge clk);
    pl_q.delete();
    for (int k = 0; k < MAXP; k++) pl_q.push_back(8'(k));
    send_frame(0, fw);
    monitor_frame(1);
    check("max_len", 32'(rx_q[5]), 32'h40);

    // bubbles
    random_payload(12);
    send_frame(1, fw);
    monitor_frame(1);

    // overflow: 65 bytes then 70 bytes, each followed by a good frame
    for (int t = 0; t < 2; t++) begin
      o0 = ovf_cnt;
      zero_viol = 0;
      watch_zero = 1'b1;
      random_payload(t == 0 ? 65 : 70);
      send_frame(0, fw);
      repeat (4) @(negedge clk);
      watch_zero = 1'b0;
      check("ovf_pulses", 32'(ovf_cnt - o0), 32'd1);
      check("ovf_no_chips", 32'(zero_viol), 32'd0);
      check("ovf_rdy", 32'({m_tready, m_busy}), 32'b10);
      random_payload(t == 0 ? 3 : 1);
      send_frame(0, fw);
      monitor_frame(0);
      check("post_ovf_len", 32'(rx_q[5]), 32'(t == 0 ? 3 : 1));
    end

    // reset during PAYLOAD
    random_payload(10);
    send_frame(0, fw);
    repeat ((4 + 2) * 8 * 16 + 40) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out", 32'({m_tready, m_busy, m_done, m_ovf, |m_txd}), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("midrst_rdy", 32'(m_tready), 32'd1);
    random_payload(5);
    send_frame(0, fw);
    monitor_frame(1);
    check("midrst_len", 32'(rx_q[5]), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
